// File: rtl/guess_entry_ctrl.sv
// Player-input front end for the hex guessing game: debounced buttons build a
// 4-digit guess, submit it to guess_checker, and track tries and win/loss.
module guess_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_TRIES       = 10,
    parameter int RESULT_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_sw,
    input  logic        btn_enter,
    input  logic        btn_back,
    input  logic        btn_new,
    input  logic [3:0]  correct_place_count,
    output logic [15:0] guess,
    output logic        guess_valid,
    output logic [2:0]  digit_count,
    output logic [3:0]  tries_used,
    output logic        game_won,
    output logic        game_lost
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WAIT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESULT_LATENCY - 1);
    localparam logic [3:0]        TRIES_MAX = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_SUBMIT,
        ST_WAIT,
        ST_WON,
        ST_LOST
    } state_t;

    // Button order in the vectors below: [0]=enter, [1]=back, [2]=new
    logic [2:0]       btn_raw;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       level;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    assign btn_raw = {btn_new, btn_back, btn_enter};

    // Synchronizer stages, then a per-button run counter; press fires with the 0->1 level change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            level   <= '0;
            press   <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync_p1[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    level[i] <= sync_p1[i];
                    press[i] <= sync_p1[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic press_enter;
    logic press_back;
    logic press_new;

    assign press_enter = press[0];
    assign press_back  = press[1];
    assign press_new   = press[2];

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Game FSM stage: all outputs registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ENTRY;
            guess       <= '0;
            digit_count <= '0;
            tries_used  <= '0;
            guess_valid <= 1'b0;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
            wait_cnt    <= '0;
        end else if (press_new) begin
            state       <= ST_ENTRY;
            guess       <= '0;
            digit_count <= '0;
            tries_used  <= '0;
            guess_valid <= 1'b0;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            guess_valid <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    if (press_enter && !press_back) begin
                        if (digit_count == 3'd4) begin
                            state       <= ST_SUBMIT;
                            guess_valid <= 1'b1;
                            tries_used  <= tries_used + 4'd1;
                        end else begin
                            guess       <= {guess[11:0], digit_sw};
                            digit_count <= digit_count + 3'd1;
                        end
                    end else if (press_back && !press_enter && digit_count != 3'd0) begin
                        guess       <= {4'h0, guess[15:4]};
                        digit_count <= digit_count - 3'd1;
                    end
                end
                ST_SUBMIT: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // Result is valid RESULT_LATENCY cycles after the strobe cycle
                    if (wait_cnt == WAIT_LAST) begin
                        if (correct_place_count == 4'd4) begin
                            state    <= ST_WON;
                            game_won <= 1'b1;
                        end else if (tries_used == TRIES_MAX) begin
                            state     <= ST_LOST;
                            game_lost <= 1'b1;
                        end else begin
                            state       <= ST_ENTRY;
                            guess       <= '0;
                            digit_count <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_WON, ST_LOST: begin
                    state <= state;
                end
                default: begin
                    state <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Bench for guess_entry_ctrl: directed button/switch sequences, a registered
// guess_checker stand-in, and a history-based behavioural model compared every cycle.
module tb_guess_entry_ctrl;

    localparam int D  = 4;
    localparam int MT = 3;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit_sw = 4'h0;
    logic        btn_enter = 1'b0;
    logic        btn_back = 1'b0;
    logic        btn_new = 1'b0;
    logic [3:0]  cpc = 4'h0;
    logic [15:0] guess;
    logic        guess_valid;
    logic [2:0]  digit_count;
    logic [3:0]  tries_used;
    logic        game_won;
    logic        game_lost;

    logic [15:0] secret = 16'hABCD;
    int checks = 0;
    int errors = 0;
    int gv_count = 0;

    always #5 clk = ~clk;

    guess_entry_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_TRIES(MT),
        .RESULT_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digit_sw(digit_sw),
        .btn_enter(btn_enter),
        .btn_back(btn_back),
        .btn_new(btn_new),
        .correct_place_count(cpc),
        .guess(guess),
        .guess_valid(guess_valid),
        .digit_count(digit_count),
        .tries_used(tries_used),
        .game_won(game_won),
        .game_lost(game_lost)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Registered guess_checker stand-in: count of digits in the right place
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cpc <= 4'h0;
        end else if (guess_valid) begin
            int m;
            m = 0;
            for (int i = 0; i < 4; i++) begin
                if (guess[4*i +: 4] == secret[4*i +: 4]) m++;
            end
            cpc <= 4'(m);
        end
    end

    // Behavioural model: raw-sample history for debounce, digit list for the guess
    bit [2:0] lvl_m;
    bit [2:0] prs_m;
    bit [2:0] rawq[$];
    int       digs[$];
    int       phase;
    int       wleft;
    bit       m_gv;
    int       m_tries;
    bit       m_won;
    bit       m_lost;

    function automatic int m_guess();
        int g;
        g = 0;
        foreach (digs[i]) g = g * 16 + digs[i];
        return g;
    endfunction

    task automatic game_step(input bit pe, input bit pb, input bit pn);
        if (pn) begin
            digs.delete();
            m_tries = 0;
            m_gv = 0;
            m_won = 0;
            m_lost = 0;
            phase = 0;
            return;
        end
        m_gv = 0;
        case (phase)
            0: begin
                if (pe && !pb) begin
                    if (digs.size() < 4) begin
                        digs.push_back(int'(digit_sw));
                    end else begin
                        phase = 1;
                        m_gv = 1;
                        m_tries++;
                    end
                end else if (pb && !pe && digs.size() > 0) begin
                    void'(digs.pop_back());
                end
            end
            1: begin
                phase = 2;
                wleft = RL;
            end
            2: begin
                wleft--;
                if (wleft == 0) begin
                    if (cpc == 4'd4) begin
                        phase = 3;
                        m_won = 1;
                    end else if (m_tries == MT) begin
                        phase = 4;
                        m_lost = 1;
                    end else begin
                        phase = 0;
                        digs.delete();
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_m = 3'b0;
            prs_m = 3'b0;
            digs.delete();
            phase = 0;
            wleft = 0;
            m_gv = 0;
            m_tries = 0;
            m_won = 0;
            m_lost = 0;
            rawq.delete();
            repeat (D + 2) rawq.push_back(3'b0);
        end else begin
            bit [2:0] newp;
            bit       diff;
            game_step(prs_m[0], prs_m[1], prs_m[2]);
            rawq.push_back({btn_new, btn_back, btn_enter});
            if (rawq.size() > D + 4) void'(rawq.pop_front());
            newp = 3'b0;
            // A level flips once the synced input (raw two edges ago) disagreed D edges running
            for (int b = 0; b < 3; b++) begin
                diff = 1'b1;
                for (int i = 0; i < D; i++) begin
                    if (rawq[rawq.size() - 3 - i][b] == lvl_m[b]) diff = 1'b0;
                end
                if (diff) begin
                    lvl_m[b] = ~lvl_m[b];
                    newp[b] = lvl_m[b];
                end
            end
            prs_m = newp;
        end
    end

    always @(negedge clk) begin
        check("guess", int'(guess), m_guess());
        check("guess_valid", int'(guess_valid), int'(m_gv));
        check("digit_count", int'(digit_count), digs.size());
        check("tries_used", int'(tries_used), m_tries);
        check("game_won", int'(game_won), int'(m_won));
        check("game_lost", int'(game_lost), int'(m_lost));
        if (!reset && guess_valid) gv_count++;
    end

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            0: btn_enter = 1'b1;
            1: btn_back = 1'b1;
            default: btn_new = 1'b1;
        endcase
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        btn_back = 1'b0;
        btn_new = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit_sw = d;
        press(0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int g0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_guess", int'(guess), 0);
        check("rst_digit_count", int'(digit_count), 0);
        check("rst_tries", int'(tries_used), 0);
        check("rst_flags", int'({game_won, game_lost, guess_valid}), 0);
        reset = 1'b0;

        // Entry of four digits
        enter_digit(4'hA);
        enter_digit(4'hB);
        enter_digit(4'hC);
        enter_digit(4'hD);
        check("t1_guess", int'(guess), 16'hABCD);
        check("t1_digit_count", int'(digit_count), 4);
        check("t1_no_valid", gv_count, 0);

        // Bouncing enter, then a steady hold
        press(2);
        check("t2_cleared", int'(digit_count), 0);
        digit_sw = 4'h5;
        for (int k = 0; k < 10; k++) begin
            btn_enter = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        check("t2_no_bounce_press", int'(digit_count), 0);
        btn_enter = 1'b1;
        lat = 0;
        while (digit_count == 3'd0 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("t2_latency_le8", int'(lat <= 8), 1);
        check("t2_guess", int'(guess), 16'h0005);
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_one_digit", int'(digit_count), 1);

        // Back at the edges
        press(2);
        enter_digit(4'h1);
        enter_digit(4'h2);
        check("t3_guess12", int'(guess), 16'h0012);
        press(1);
        check("t3_guess01", int'(guess), 16'h0001);
        press(1);
        check("t3_guess00", int'(guess), 16'h0000);
        press(1);
        check("t3_extra_back_guess", int'(guess), 16'h0000);
        check("t3_extra_back_count", int'(digit_count), 0);

        // Winning submission
        press(2);
        enter_digit(4'hA);
        enter_digit(4'hB);
        enter_digit(4'hC);
        enter_digit(4'hD);
        gv_count = 0;
        press(0);
        check("t4_one_valid", gv_count, 1);
        check("t4_tries", int'(tries_used), 1);
        check("t4_won", int'(game_won), 1);
        check("t4_lost", int'(game_lost), 0);
        enter_digit(4'h0);
        check("t4_frozen_guess", int'(guess), 16'hABCD);
        check("t4_still_won", int'(game_won), 1);

        // Three wrong submissions
        press(2);
        for (int t = 0; t < 3; t++) begin
            enter_digit(4'h1);
            enter_digit(4'h2);
            enter_digit(4'h3);
            enter_digit(4'h4);
            press(0);
        end
        check("t5_tries", int'(tries_used), 3);
        check("t5_lost", int'(game_lost), 1);
        check("t5_not_won", int'(game_won), 0);
        press(2);
        check("t5_new_all_zero",
              int'({guess, digit_count, tries_used, game_won, game_lost, guess_valid}), 0);

        // Async reset while waiting on the checker and mid-debounce
        enter_digit(4'h9);
        enter_digit(4'h8);
        enter_digit(4'h7);
        enter_digit(4'h6);
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_back = 1'b1;
        lat = 0;
        while (!guess_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t6_submit_seen", int'(guess_valid), 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_async_zero",
              int'({guess, digit_count, tries_used, game_won, game_lost, guess_valid}), 0);
        btn_enter = 1'b0;
        btn_back = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        g0 = gv_count;
        repeat (20) @(negedge clk);
        check("t6_no_valid_after", gv_count, g0);
        check("t6_outputs_zero",
              int'({guess, digit_count, tries_used, game_won, game_lost}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
